// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock, optionally followed by an even-parity bit.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             frame,
  output logic             done
);

  localparam int N  = WIDTH + PARITY_EN;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   order;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Lays the word out so that bit 0 of the result is the first bit on the line.
  function automatic logic [N-1:0] tx_order(input logic [WIDTH-1:0] d);
    logic [N-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[i] = (LSB_FIRST != 0) ? d[i] : d[WIDTH-1-i];
    end
    if (PARITY_EN != 0) begin
      f[N-1] = even_parity(d);
    end
    return f;
  endfunction

  assign order = tx_order(data_in);

  // Handshake, shift sequencing and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      load_ready <= 1'b1;
      ser_out    <= 1'b0;
      frame      <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            ser_out    <= order[0];
            shreg      <= {1'b0, order[N-1:1]};
            cnt        <= '0;
            frame      <= 1'b1;
            load_ready <= 1'b0;
            state      <= SHIFT;
          end else begin
            ser_out    <= 1'b0;
            frame      <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        SHIFT: begin
          // cnt holds the index of the bit currently on the line.
          if (cnt == CW'(N - 1)) begin
            ser_out    <= 1'b0;
            frame      <= 1'b0;
            done       <= 1'b1;
            load_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            ser_out    <= shreg[0];
            shreg      <= {1'b0, shreg[N-1:1]};
            cnt        <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          ser_out    <= 1'b0;
          frame      <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: three configurations (MSB-first, LSB-first,
// MSB-first with parity) share one stimulus stream and are checked against a timing model.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] data_in;
  logic [2:0] rdy, ser, frm, dn;

  int checks = 0;
  int errors = 0;

  // Model state per configuration: remaining busy cycles, expected done, expected words.
  int         mb [3] = '{default: 0};
  logic       md [3] = '{default: 1'b0};
  logic [7:0] exp_mem [3][64];
  int         wr [3] = '{default: 0};
  int         rd [3] = '{default: 0};

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy[0]), .ser_out(ser[0]), .frame(frm[0]), .done(dn[0]));
  piso_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy[1]), .ser_out(ser[1]), .frame(frm[1]), .done(dn[1]));
  piso_tx #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(1)) u_par (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy[2]), .ser_out(ser[2]), .frame(frm[2]), .done(dn[2]));

  function automatic int nbits(input int d);
    return (d == 2) ? 9 : 8;
  endfunction

  // Bit k of the transmit order for configuration d.
  function automatic logic exp_bit(input int d, input logic [7:0] w, input int k);
    if (d == 2 && k == 8) return ^w;
    if (d == 1) return w[k];
    return w[7-k];
  endfunction

  task automatic chk1(input string name, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %b expected %b", name, d, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  // Reference: a word is accepted when idle, then the line is busy for N cycles.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        mb[d] <= 0;
        md[d] <= 1'b0;
      end else begin
        md[d] <= (mb[d] == 1);
        if (mb[d] == 0 && load_valid) begin
          mb[d] <= nbits(d);
          exp_mem[d][wr[d] % 64] <= data_in;
          wr[d] <= wr[d] + 1;
        end else if (mb[d] > 0) begin
          mb[d] <= mb[d] - 1;
        end
      end
    end
  end

  // Monitor: per-cycle timing checks and per-frame content checks against the scoreboard.
  initial begin
    logic       pf [3];
    int         cnt [3];
    logic [8:0] bits [3];
    logic [7:0] w;
    for (int d = 0; d < 3; d++) begin
      pf[d] = 1'b0; cnt[d] = 0; bits[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          pf[d] = 1'b0;
          cnt[d] = 0;
          rd[d] = wr[d];
        end else begin
          chk1("load_ready", d, rdy[d], mb[d] == 0);
          chk1("frame", d, frm[d], mb[d] != 0);
          chk1("done", d, dn[d], md[d]);
          if (frm[d]) begin
            if (cnt[d] < 9) bits[d][cnt[d]] = ser[d];
            cnt[d]++;
          end else begin
            chk1("idle_ser", d, ser[d], 1'b0);
            if (pf[d]) begin
              chk32("frame_len", d, cnt[d], nbits(d));
              if (rd[d] == wr[d]) begin
                checks++; errors++;
                $display("FAIL underflow[%0d] at %0t: got a frame, expected none", d, $time);
              end else begin
                w = exp_mem[d][rd[d] % 64];
                rd[d]++;
                for (int k = 0; k < nbits(d); k++) begin
                  checks++;
                  if (bits[d][k] !== exp_bit(d, w, k)) begin
                    errors++;
                    $display("FAIL bit[%0d] word %h bit %0d at %0t: got %b expected %b",
                             d, w, k, $time, bits[d][k], exp_bit(d, w, k));
                  end
                end
              end
            end
            cnt[d] = 0;
          end
          pf[d] = frm[d];
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!(mb[0] == 0 && mb[1] == 0 && mb[2] == 0) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", t);
    end
  endtask

  task automatic send(input logic [7:0] w);
    wait_idle();
    data_in = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(input string name);
    for (int d = 0; d < 3; d++) begin
      chk1({name, "_ready"}, d, rdy[d], 1'b1);
      chk1({name, "_ser"}, d, ser[d], 1'b0);
      chk1({name, "_frame"}, d, frm[d], 1'b0);
      chk1({name, "_done"}, d, dn[d], 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_init");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hA5);
    send(8'h81);
    send(8'h06);
    send(8'h07);
    send(8'h03);

    // Valid held high; data changes mid-frame, second frame picks up the new word.
    wait_idle();
    data_in = 8'hF0;
    load_valid = 1'b1;
    repeat (3) @(negedge clk);
    data_in = 8'h0F;
    repeat (12) @(negedge clk);
    load_valid = 1'b0;

    // Abort a frame after three bits with an asynchronous reset.
    send(8'hFF);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C);

    repeat (300) begin
      @(negedge clk);
      load_valid = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
    end
    load_valid = 1'b0;

    repeat (30) @(negedge clk);
    for (int d = 0; d < 3; d++) chk32("drained", d, rd[d], wr[d]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial bit stream that our D-flop shift chains capture.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on ser_out.
- frame is high while bits are on the line. done pulses when the word completes.
- An optional even-parity bit can be appended after the data bits.

Parameters:
- WIDTH, 8: data word width; legal range 2..32.
- LSB_FIRST, 0: 0 shifts MSB first, 1 shifts LSB first.
- PARITY_EN, 0: 1 appends one even-parity bit after the data bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  WIDTH  word to transmit; sampled only on handshake
- load_valid  input  1  producer has a word on data_in
- load_ready  output  1  transmitter idle and able to accept
- ser_out  output  1  serial data bit (registered)
- frame  output  1  high exactly while a data or parity bit is driven on ser_out
- done  output  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately and at any time):
  - load_ready=1, ser_out=0, frame=0, done=0.
  - Internal shift register and bit counter are cleared; state is IDLE.
- Frame length: N = WIDTH + PARITY_EN bits.
- States are IDLE and SHIFT. All outputs are registered.
- IDLE:
  - load_ready=1, frame=0, ser_out=0.
  - Handshake at rising edge E when load_valid && load_ready.
  - At E: capture data_in, compute parity = XOR of all data bits, and register the first bit onto ser_out (MSB if LSB_FIRST=0, else LSB).
  - Also at E: frame<=1, load_ready<=0, counter<=0, go to SHIFT.
- SHIFT:
  - At each edge E+k, for k=1..N-1: ser_out<=bit k of the transmit order, counter increments.
  - The parity bit, when enabled, is bit N-1.
  - At edge E+N: ser_out<=0, frame<=0, done<=1, load_ready<=1, go to IDLE.
  - done is cleared at the following edge.
- Timing:
  - ser_out holds bit k during the cycle after edge E+k; frame is high for exactly N cycles.
  - The earliest next handshake is edge E+N+1, so consecutive frames are separated by one idle cycle with frame=0.
- Boundary conditions:
  - load_valid while load_ready=0 is ignored: no capture, no state change.
  - data_in changing mid-frame has no effect on the transmitted bits.
  - Reset mid-frame aborts the frame immediately with no done pulse. The next frame starts cleanly after rst_n deasserts.
  - load_valid held high continuously produces back-to-back frames with a 1-cycle gap.
  - The counter width is enough to hold N-1 without overflow; the counter never wraps inside a frame.
  - The parity bit is even parity: the XOR over data bits plus parity bit equals 0.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> outputs immediately load_ready=1, ser_out=0, frame=0, done=0; hold 2 cycles, release.
- MSB-first, WIDTH=8, PARITY_EN=0, data_in=8'hA5 accepted at edge E:
  - ser_out after E..E+7 = 1,0,1,0,0,1,0,1.
  - frame high 8 cycles; done=1 for one cycle after E+8; load_ready=0 from E to E+8.
- LSB_FIRST=1, data_in=8'h81 -> ser_out sequence 1,0,0,0,0,0,0,1; data_in=8'h06 -> 0,1,1,0,0,0,0,0.
- PARITY_EN=1, data_in=8'h07:
  - frame high 9 cycles; ninth bit=1.
  - Repeat with 8'h03 -> ninth bit=0.
- Busy/back-to-back:
  - Drive load_valid=1 continuously with 8'hF0 then change data_in to 8'h0F mid-frame; the first frame shifts 8'hF0 unchanged.
  - The second frame (8'h0F) starts at edge E+9 after a single frame=0 cycle.
- Reset mid-frame: pull rst_n low after 3 bits of 8'hFF -> frame drops immediately; no done pulse; a subsequent 8'h3C transmits correctly.
